// File: rtl/axil_read_arbiter_2to1.sv
// axil_read_arbiter_2to1: shares one AXI4-Lite read-only slave between two
// AXI4-Lite read masters. One read is in flight at a time. Simultaneous
// requests are granted round-robin, and every control output comes from a flop.
// Optional feature macro: AXIL_ARB_DECERR_EN. When it is defined, a granted
// address >= SLAVE_SPAN is answered locally with DECERR and no downstream access.
module axil_read_arbiter_2to1 #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned SLAVE_SPAN     = 32'h0008
) (
  input  logic                      aclk,
  input  logic                      areset,

  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,

  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,

  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_grant_q, last_grant_d;
  logic                      decerr_q, decerr_d;

  logic [AXI_ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
  logic                      m_arvalid_q, m_arvalid_d;
  logic                      m_rready_q, m_rready_d;

  logic                      s0_arready_q, s0_arready_d;
  logic                      s0_rvalid_q, s0_rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] s0_rdata_q, s0_rdata_d;
  logic [1:0]                s0_rresp_q, s0_rresp_d;

  logic                      s1_arready_q, s1_arready_d;
  logic                      s1_rvalid_q, s1_rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] s1_rdata_q, s1_rdata_d;
  logic [1:0]                s1_rresp_q, s1_rresp_d;

  logic                      req_any_c;
  logic                      sel_c;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr_c;
  logic                      sel_oob_c;
  logic                      resp_done_c;

  // Requester selection: a sole requester wins; on contention the master
  // that was not served last wins, so simultaneous requests alternate.
  assign req_any_c  = s0_axi_arvalid | s1_axi_arvalid;
  assign sel_c      = (s0_axi_arvalid && s1_axi_arvalid) ? ~last_grant_q : s1_axi_arvalid;
  assign sel_addr_c = sel_c ? s1_axi_araddr : s0_axi_araddr;

`ifdef AXIL_ARB_DECERR_EN
  // Address outside the downstream slave: answer locally with DECERR.
  assign sel_oob_c = (32'(sel_addr_c) >= 32'(SLAVE_SPAN));
`else
  // Every address goes downstream; the span is not needed in this build.
  logic unused_span_c;
  assign unused_span_c = ^32'(SLAVE_SPAN);
  assign sel_oob_c     = 1'b0;
`endif

  // The granted master accepts the response it is holding.
  assign resp_done_c = grant_q ? (s1_rvalid_q && s1_axi_rready)
                               : (s0_rvalid_q && s0_axi_rready);

  // Next-state and next-output logic for the single-outstanding read FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    decerr_d     = decerr_q;
    m_araddr_d   = m_araddr_q;
    m_arvalid_d  = m_arvalid_q;
    m_rready_d   = m_rready_q;
    s0_arready_d = 1'b0;
    s1_arready_d = 1'b0;
    s0_rvalid_d  = s0_rvalid_q;
    s0_rdata_d   = s0_rdata_q;
    s0_rresp_d   = s0_rresp_q;
    s1_rvalid_d  = s1_rvalid_q;
    s1_rdata_d   = s1_rdata_q;
    s1_rresp_d   = s1_rresp_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any_c) begin
          grant_d      = sel_c;
          s0_arready_d = ~sel_c;
          s1_arready_d = sel_c;
          if (sel_oob_c) begin
            decerr_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            m_araddr_d  = sel_addr_c;
            m_arvalid_d = 1'b1;
            state_d     = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (m_axi_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = ST_DATA;
        end
      end

      ST_DATA: begin
        if (m_axi_rvalid && m_rready_q) begin
          m_rready_d = 1'b0;
          if (grant_q) begin
            s1_rvalid_d = 1'b1;
            s1_rdata_d  = m_axi_rdata;
            s1_rresp_d  = m_axi_rresp;
          end else begin
            s0_rvalid_d = 1'b1;
            s0_rdata_d  = m_axi_rdata;
            s0_rresp_d  = m_axi_rresp;
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (decerr_q) begin
          // Local error response, presented one cycle after the arready pulse.
          decerr_d = 1'b0;
          if (grant_q) begin
            s1_rvalid_d = 1'b1;
            s1_rdata_d  = '0;
            s1_rresp_d  = RESP_DECERR;
          end else begin
            s0_rvalid_d = 1'b1;
            s0_rdata_d  = '0;
            s0_rresp_d  = RESP_DECERR;
          end
        end else if (resp_done_c) begin
          s0_rvalid_d  = 1'b0;
          s0_rdata_d   = '0;
          s0_rresp_d   = RESP_OKAY;
          s1_rvalid_d  = 1'b0;
          s1_rdata_d   = '0;
          s1_rresp_d   = RESP_OKAY;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any read in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      decerr_q     <= 1'b0;
      m_araddr_q   <= '0;
      m_arvalid_q  <= 1'b0;
      m_rready_q   <= 1'b0;
      s0_arready_q <= 1'b0;
      s0_rvalid_q  <= 1'b0;
      s0_rdata_q   <= '0;
      s0_rresp_q   <= RESP_OKAY;
      s1_arready_q <= 1'b0;
      s1_rvalid_q  <= 1'b0;
      s1_rdata_q   <= '0;
      s1_rresp_q   <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      decerr_q     <= decerr_d;
      m_araddr_q   <= m_araddr_d;
      m_arvalid_q  <= m_arvalid_d;
      m_rready_q   <= m_rready_d;
      s0_arready_q <= s0_arready_d;
      s0_rvalid_q  <= s0_rvalid_d;
      s0_rdata_q   <= s0_rdata_d;
      s0_rresp_q   <= s0_rresp_d;
      s1_arready_q <= s1_arready_d;
      s1_rvalid_q  <= s1_rvalid_d;
      s1_rdata_q   <= s1_rdata_d;
      s1_rresp_q   <= s1_rresp_d;
    end
  end

  assign m_axi_araddr   = m_araddr_q;
  assign m_axi_arvalid  = m_arvalid_q;
  assign m_axi_rready   = m_rready_q;

  assign s0_axi_arready = s0_arready_q;
  assign s0_axi_rvalid  = s0_rvalid_q;
  assign s0_axi_rdata   = s0_rdata_q;
  assign s0_axi_rresp   = s0_rresp_q;

  assign s1_axi_arready = s1_arready_q;
  assign s1_axi_rvalid  = s1_rvalid_q;
  assign s1_axi_rdata   = s1_rdata_q;
  assign s1_axi_rresp   = s1_rresp_q;

endmodule

// File: tb/tb_axil_read_arbiter_2to1.sv
// Bench for axil_read_arbiter_2to1: directed reads. The expected responses
// go into queues. Reactive slave and master monitors pop and compare them.
module tb_axil_read_arbiter_2to1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic        aclk;
  logic        areset;
  logic [15:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic        s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
  logic        s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
  logic [31:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  int pass_cnt = 0;
  int total_cnt = 0;

  rsp_t        exp_q0[$];
  rsp_t        exp_q1[$];
  rsp_t        slv_q[$];
  logic [15:0] exp_addr_q[$];

  int ar_stall = 0;
  int r_stall = 0;
  int rready_hold[2];
  int done_cnt = 0;
  int ar_cnt = 0;

  axil_read_arbiter_2to1 dut (
    .aclk(aclk), .areset(areset),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata),
    .s0_axi_rresp(s0_axi_rresp), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata),
    .s1_axi_rresp(s1_axi_rresp), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  // Queue one transaction in the order the slave will see it.
  task automatic expect_txn(input int m, input logic [15:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input bit downstream);
    rsp_t e;
    e.data = data;
    e.resp = resp;
    if (downstream) begin
      exp_addr_q.push_back(addr);
      slv_q.push_back(e);
    end
    if (m == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) s0_axi_rready = v;
    else        s1_axi_rready = v;
  endtask

  // Hold arvalid until arready is seen, then release it one cycle later.
  task automatic issue(input int m, input logic [15:0] addr);
    bit got;
    got = 1'b0;
    @(negedge aclk);
    if (m == 0) begin s0_axi_araddr = addr; s0_axi_arvalid = 1'b1; end
    else        begin s1_axi_araddr = addr; s1_axi_arvalid = 1'b1; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge aclk);
      got = (m == 0) ? s0_axi_arready : s1_axi_arready;
    end
    if (!got) chk($sformatf("s%0d_arready_timeout", m), 32'd0, 32'd1);
    @(negedge aclk);
    if (m == 0) s0_axi_arvalid = 1'b0;
    else        s1_axi_arvalid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s0_arready"}, 32'(s0_axi_arready), 32'd0);
    chk({tag, "_s0_rvalid"},  32'(s0_axi_rvalid),  32'd0);
    chk({tag, "_s0_rdata"},   s0_axi_rdata,        32'd0);
    chk({tag, "_s0_rresp"},   32'(s0_axi_rresp),   32'd0);
    chk({tag, "_s1_arready"}, 32'(s1_axi_arready), 32'd0);
    chk({tag, "_s1_rvalid"},  32'(s1_axi_rvalid),  32'd0);
    chk({tag, "_s1_rdata"},   s1_axi_rdata,        32'd0);
    chk({tag, "_s1_rresp"},   32'(s1_axi_rresp),   32'd0);
    chk({tag, "_m_araddr"},   32'(m_axi_araddr),   32'd0);
    chk({tag, "_m_arvalid"},  32'(m_axi_arvalid),  32'd0);
    chk({tag, "_m_rready"},   32'(m_axi_rready),   32'd0);
  endtask

  // Wait for every queued transaction to drain, within a bounded number of cycles.
  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge aclk);
      idle = (exp_q0.size() == 0) && (exp_q1.size() == 0) && (slv_q.size() == 0)
             && (exp_addr_q.size() == 0) && !s0_axi_rvalid && !s1_axi_rvalid;
    end
    chk({tag, "_drained"}, 32'(idle), 32'd1);
    repeat (2) @(negedge aclk);
  endtask

  // Reactive downstream slave: stalls arready/rvalid and returns queued data.
  initial begin : slave_model
    int aw, rw;
    bit r_pend, prev_rready;
    logic [15:0] first_addr, ea;
    rsp_t e;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    aw = 0; rw = 0; r_pend = 1'b0; prev_rready = 1'b0; first_addr = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
        aw = 0; rw = 0; r_pend = 1'b0; prev_rready = 1'b0;
        continue;
      end
      if (m_axi_arready) begin
        m_axi_arready = 1'b0;
        r_pend = 1'b1;
        rw = 0;
      end else if (m_axi_arvalid) begin
        if (aw == 0) first_addr = m_axi_araddr;
        else chk("m_araddr_stable", 32'(m_axi_araddr), 32'(first_addr));
        if (aw >= ar_stall) begin
          m_axi_arready = 1'b1;
          aw = 0;
          if (exp_addr_q.size() == 0) chk("slave_unexpected_ar", 32'(m_axi_araddr), 32'hFFFF_FFFF);
          else begin
            ea = exp_addr_q.pop_front();
            chk("m_araddr", 32'(m_axi_araddr), 32'(ea));
          end
        end else aw++;
      end
      if (m_axi_rvalid) begin
        if (prev_rready) begin
          m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; r_pend = 1'b0;
        end
      end else if (r_pend && m_axi_rready) begin
        if (rw >= r_stall) begin
          rw = 0;
          if (slv_q.size() == 0) begin
            chk("slave_data_underflow", 32'd0, 32'd1);
            e = '0;
          end else e = slv_q.pop_front();
          m_axi_rvalid = 1'b1; m_axi_rdata = e.data; m_axi_rresp = e.resp;
        end else rw++;
      end
      prev_rready = m_axi_rready;
    end
  end

  // Per-master monitor: drives rready after a hold and scores the response.
  task automatic mon_master(input int m);
    int hold;
    logic rv;
    logic [31:0] rd, cap_d;
    logic [1:0] rr, cap_r;
    rsp_t e;
    hold = 0; cap_d = '0; cap_r = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin hold = 0; set_rready(m, 1'b0); continue; end
      rv = (m == 0) ? s0_axi_rvalid : s1_axi_rvalid;
      rd = (m == 0) ? s0_axi_rdata  : s1_axi_rdata;
      rr = (m == 0) ? s0_axi_rresp  : s1_axi_rresp;
      if (!rv) begin
        hold = 0;
        set_rready(m, 1'b0);
      end else begin
        if (hold == 0) begin cap_d = rd; cap_r = rr; end
        else begin
          chk($sformatf("s%0d_rdata_stable", m), rd, cap_d);
          chk($sformatf("s%0d_rresp_stable", m), 32'(rr), 32'(cap_r));
        end
        if (hold < rready_hold[m]) begin
          hold++;
          set_rready(m, 1'b0);
        end else begin
          hold = 0;
          if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0))
            chk($sformatf("s%0d_unexpected_rvalid", m), rd, 32'hFFFF_FFFF);
          else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("s%0d_rdata", m), rd, e.data);
            chk($sformatf("s%0d_rresp", m), 32'(rr), 32'(e.resp));
          end
          done_cnt++;
          set_rready(m, 1'b1);
        end
      end
    end
  endtask

  initial mon_master(0);
  initial mon_master(1);

  // Protocol monitor: grant exclusivity, idle outputs zero, no arready while busy.
  initial begin : proto_mon
    bit prev_ar;
    prev_ar = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin prev_ar = 1'b0; continue; end
      if (!s0_axi_rvalid) chk("s0_idle_zero", {s0_axi_rdata[31:2], s0_axi_rdata[1:0] | s0_axi_rresp}, 32'd0);
      if (!s1_axi_rvalid) chk("s1_idle_zero", {s1_axi_rdata[31:2], s1_axi_rdata[1:0] | s1_axi_rresp}, 32'd0);
      if (s0_axi_arready || s1_axi_arready) begin
        chk("arready_onehot", 32'(s0_axi_arready & s1_axi_arready), 32'd0);
        chk("arready_single_cycle", 32'(prev_ar), 32'd0);
        chk("arready_while_busy", 32'(done_cnt), 32'(ar_cnt));
        ar_cnt++;
        prev_ar = 1'b1;
      end else prev_ar = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    rready_hold[0] = 0; rready_hold[1] = 0;
    areset = 1'b1;
    s0_axi_araddr = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
    s1_axi_araddr = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
    do_reset();
    @(negedge aclk);
    check_all_zero("rst");

    // Single s0 read with cycle-exact latency checks.
    expect_txn(0, 16'h0004, 32'h1234_5678, 2'b00, 1'b1);
    @(negedge aclk);
    s0_axi_araddr = 16'h0004; s0_axi_arvalid = 1'b1;
    @(negedge aclk);
    chk("lat1_s0_arready", 32'(s0_axi_arready), 32'd1);
    chk("lat1_m_arvalid",  32'(m_axi_arvalid),  32'd1);
    chk("lat1_m_araddr",   32'(m_axi_araddr),   32'h0004);
    chk("lat1_s1_arready", 32'(s1_axi_arready), 32'd0);
    @(negedge aclk);
    s0_axi_arvalid = 1'b0;
    chk("lat2_m_rready",   32'(m_axi_rready),   32'd1);
    chk("lat2_m_arvalid",  32'(m_axi_arvalid),  32'd0);
    chk("lat2_s0_arready", 32'(s0_axi_arready), 32'd0);
    @(negedge aclk);
    chk("lat3_s0_rvalid",  32'(s0_axi_rvalid),  32'd1);
    chk("lat3_m_rready",   32'(m_axi_rready),   32'd0);
    chk("lat3_s1_rvalid",  32'(s1_axi_rvalid),  32'd0);
    @(negedge aclk);
    chk("lat4_s0_rvalid",  32'(s0_axi_rvalid),  32'd0);
    wait_idle("t1");

    // Simultaneous pair after reset: s0 first, then s1.
    do_reset();
    expect_txn(0, 16'h0000, 32'hA0A0_0000, 2'b00, 1'b1);
    expect_txn(1, 16'h0004, 32'hB1B1_0004, 2'b00, 1'b1);
    fork
      issue(0, 16'h0000);
      issue(1, 16'h0004);
    join
    wait_idle("rr_a");
    // Lone s0 read, then another pair: s1 now wins.
    expect_txn(0, 16'h0002, 32'h0000_2222, 2'b00, 1'b1);
    issue(0, 16'h0002);
    wait_idle("rr_single");
    expect_txn(1, 16'h0006, 32'hB1B1_0006, 2'b00, 1'b1);
    expect_txn(0, 16'h0000, 32'hA0A0_1000, 2'b00, 1'b1);
    fork
      issue(0, 16'h0000);
      issue(1, 16'h0006);
    join
    wait_idle("rr_b");

    // Stalling slave and slow s1, with s0 requesting while busy.
    ar_stall = 5; r_stall = 3; rready_hold[1] = 4;
    expect_txn(1, 16'h0006, 32'h0BAD_BEEF, 2'b00, 1'b1);
    expect_txn(0, 16'h0002, 32'h1111_2222, 2'b00, 1'b1);
    fork
      issue(1, 16'h0006);
      begin repeat (3) @(negedge aclk); issue(0, 16'h0002); end
    join
    wait_idle("stall");
    ar_stall = 0; r_stall = 0; rready_hold[1] = 0;

    // Reset while in DATA abandons the read; then a fresh s1 read.
    r_stall = 20;
    expect_txn(0, 16'h0002, 32'hDEAD_0002, 2'b00, 1'b1);
    issue(0, 16'h0002);
    chk("mid_rst_in_data", 32'(m_axi_rready), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check_all_zero("mid_rst");
    exp_q0.delete(); exp_q1.delete(); slv_q.delete(); exp_addr_q.delete();
    done_cnt = ar_cnt;
    areset = 1'b0;
    r_stall = 0;
    expect_txn(1, 16'h0006, 32'h5A5A_0006, 2'b00, 1'b1);
    issue(1, 16'h0006);
    wait_idle("post_rst");

    // SLVERR response is forwarded unmodified.
    expect_txn(0, 16'h0004, 32'hCAFE_F00D, 2'b10, 1'b1);
    issue(0, 16'h0004);
    wait_idle("slverr");

    // Out-of-span address.
`ifdef AXIL_ARB_DECERR_EN
    expect_txn(1, 16'h0010, 32'h0000_0000, 2'b11, 1'b0);
`else
    expect_txn(1, 16'h0010, 32'h7777_0010, 2'b00, 1'b1);
`endif
    issue(1, 16'h0010);
    wait_idle("span");

    chk("final_ar_vs_done", 32'(ar_cnt), 32'(done_cnt));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axil_read_arbiter_2to1.md
Name: axil_read_arbiter_2to1

Overview:
- Shares one AXI4-Lite read-only slave between two AXI4-Lite read masters, e.g. processor and debug/DMA path both reading a 64-bit readback register block.
- Read-address and read-data channels only; write channels are out of scope.
- One transaction outstanding at a time; round-robin grant; all control outputs registered.

Parameters:
AXI_DATA_WIDTH, 32, width of rdata on all ports
AXI_ADDR_WIDTH, 16, width of araddr on all ports
SLAVE_SPAN, 16'h0008, byte span of downstream slave; used only when AXIL_ARB_DECERR_EN is defined

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s0_axi_araddr  in  AXI_ADDR_WIDTH  master 0 read address
s0_axi_arvalid  in  1  master 0 address valid
s0_axi_arready  out  1  master 0 address ready
s0_axi_rdata  out  AXI_DATA_WIDTH  master 0 read data
s0_axi_rresp  out  2  master 0 read response
s0_axi_rvalid  out  1  master 0 read data valid
s0_axi_rready  in  1  master 0 read data ready
s1_axi_*  (same seven signals)  master 1
m_axi_araddr  out  AXI_ADDR_WIDTH  to shared slave
m_axi_arvalid  out  1  to shared slave
m_axi_arready  in  1  from shared slave
m_axi_rdata  in  AXI_DATA_WIDTH  from shared slave
m_axi_rresp  in  2  from shared slave
m_axi_rvalid  in  1  from shared slave
m_axi_rready  out  1  to shared slave

Behaviour:
- Interface: one clock `aclk`; `areset` is synchronous, active-high.
- Reset (areset=1 at a clock edge):
  - all arready/rvalid/arvalid/rready outputs = 0; rdata = 0; rresp = 2'b00; m_axi_araddr = 0.
  - state = IDLE; last_grant = 1, so master 0 wins the first contention.
  - Reset mid-transaction abandons it silently; no response is issued.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any sN_arvalid is high, select a requester: sole requester wins; if both, the one != last_grant wins.
  - Next edge: pulse sN_arready=1 for exactly one cycle; latch araddr into m_axi_araddr; m_axi_arvalid=1; grant=N; go to ADDR.
- ADDR:
  - Hold m_axi_arvalid and m_axi_araddr stable until m_axi_arready=1.
  - On that edge: m_axi_arvalid=0, m_axi_rready=1, go to DATA.
- DATA:
  - On m_axi_rvalid=1 (with rready=1): capture m_axi_rdata/rresp into the granted sN_axi_rdata/rresp; m_axi_rready=0; sN_axi_rvalid=1; go to RESP.
- RESP:
  - Hold sN rvalid/rdata/rresp stable until sN_axi_rready=1.
  - On that edge: rvalid=0, rdata cleared to 0, last_grant=N, go to IDLE.
- Non-granted master: rvalid=0, arready=0, rdata=0, rresp=0 throughout.
- Minimum latency, zero-wait slave and master (edge counts from arvalid sampled high in IDLE):
  - arready at +1, m_arvalid at +1..+1, m_rready at +2, sN_rvalid at +3, IDLE at +4.
  - Back-to-back minimum is 4 cycles per read.
- A new arvalid asserted while busy waits; its arready stays 0 until the block returns to IDLE.
- Simultaneous requests in IDLE alternate strictly; a single continuous requester is never starved by itself.
- m_axi_rresp is forwarded unmodified; m_axi_rvalid outside DATA is ignored (rready=0).

Optional Feature:
- Macro: AXIL_ARB_DECERR_EN.
- Defined:
  - In IDLE, a granted address >= SLAVE_SPAN skips ADDR/DATA and goes directly to RESP.
  - Response: rdata=0, rresp=2'b11 (DECERR); sN_rvalid asserts one cycle after arready.
  - No downstream traffic; last_grant still updates.
- Not defined: every address is forwarded downstream; SLAVE_SPAN is unused.

Test Plan:
- Reset then s0 reads 0x0004, slave returns 0x12345678 OKAY with zero wait -> s0_arready at +1, m_araddr=0x0004, s0_rdata=0x12345678, rresp=00, rvalid at +3; s1 outputs stay 0.
- s0 and s1 arvalid together (addr 0x0000 / 0x0004) -> s0 served first, then s1; m_araddr sequence 0x0000, 0x0004; next simultaneous pair serves s1 first.
- Slave stalls arready 5 cycles and rvalid 3 cycles, s1 holds rready low 4 cycles -> m_arvalid/m_araddr stable 5 cycles; s1_rvalid/rdata stable until rready; no second arready issued meanwhile.
- areset pulsed while in DATA -> next cycle all outputs 0, state IDLE; a subsequent s1 read completes normally with fresh data.
- Slave returns rresp=2'b10 with rdata=0xCAFEF00D -> granted master sees rresp=10, rdata=0xCAFEF00D.
- With AXIL_ARB_DECERR_EN, SLAVE_SPAN=8, s1 reads 0x0010 -> s1_rresp=11, rdata=0, m_arvalid never asserts; without the macro -> m_araddr=0x0010 is issued.
